// File: rtl/iir_allpole_pkg.sv
// Shared types and arithmetic helpers for the serial all-pole IIR filter.
// Optional saturation is selected in the top level by IIR_ALLPOLE_SAT_EN.
package iir_allpole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  function automatic int calc_accw(input int dw, input int cw, input int ntap);
    return dw + cw + $clog2(ntap) + 2;
  endfunction

  // Keep the low dw bits and sign-extend them back to 64 bits.
  function automatic logic signed [63:0] wrap_to(input logic signed [63:0] v, input int dw);
    logic signed [63:0] t;
    t = v <<< (64 - dw);
    return t >>> (64 - dw);
  endfunction

  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Feedback coefficient register file a[1..NTAP]; writes land only while the
// filter is idle, reads are combinational by tap index.
module iir_coef_bank
  import iir_allpole_pkg::*;
#(
  parameter int NTAP = 8,
  parameter int CW   = 8,
  parameter int AW   = 4,
  parameter int RAW  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_idle,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic signed [CW-1:0]  i_data,
  input  logic [RAW-1:0]        i_rd_addr,
  output logic signed [CW-1:0]  o_rd_data
);

  logic signed [CW-1:0] r_coef [1:NTAP];

  // Coefficient storage; addresses 0 and above NTAP match no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= NTAP; i++) r_coef[i] <= '0;
    end else begin
      for (int i = 1; i <= NTAP; i++) begin
        if (i_we && i_idle && (i_addr == AW'(i))) r_coef[i] <= i_data;
      end
    end
  end

  // Tap read mux; out-of-range indices read as zero.
  always_comb begin
    o_rd_data = '0;
    for (int i = 1; i <= NTAP; i++) begin
      o_rd_data = (i_rd_addr == RAW'(i)) ? r_coef[i] : o_rd_data;
    end
  end

endmodule

// File: rtl/iir_allpole_serial.sv
// Serial all-pole IIR: y[n] = x[n] - sum a[k]*y[n-k], one tap per clock.
// Define IIR_ALLPOLE_SAT_EN for saturating output and a sticky sat_flag port.
module iir_allpole_serial
  import iir_allpole_pkg::*;
#(
  parameter  int DW    = 8,
  parameter  int CW    = 8,
  parameter  int CFRAC = 6,
  parameter  int NTAP  = 8,
  localparam int KW    = $clog2(NTAP + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] y_out,
  input  logic [KW-1:0]        n_taps,
  input  logic                 coef_we,
  input  logic [KW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 clr
`ifdef IIR_ALLPOLE_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  localparam int ACCW = calc_accw(DW, CW, NTAP);
  localparam int PW   = DW + CW;

  state_e                r_state;
  state_e                w_next;
  logic signed [ACCW-1:0] r_acc;
  logic [KW:0]           r_k;
  logic [KW-1:0]         r_ntap_q;
  logic [KW-1:0]         w_ntap_in;
  logic signed [DW-1:0]  r_yh [1:NTAP];
  logic signed [CW-1:0]  w_coef;
  logic signed [DW-1:0]  w_yh_k;
  logic signed [PW-1:0]  w_prod;
  logic signed [63:0]    w_acc_ext;
  logic signed [63:0]    w_acc_shift;
  logic signed [DW-1:0]  w_y;
  logic                  w_accept;
  logic                  w_mac_step;

  assign in_ready   = (r_state == IDLE);
  assign w_accept   = in_valid && (r_state == IDLE);
  assign w_mac_step = (r_k <= {1'b0, r_ntap_q});
  assign w_ntap_in  = (n_taps > KW'(NTAP)) ? KW'(NTAP) : n_taps;
  assign w_prod     = PW'(w_coef) * PW'(w_yh_k);
  assign w_acc_ext  = {{(64 - ACCW){r_acc[ACCW-1]}}, r_acc};
  assign w_acc_shift = w_acc_ext >>> CFRAC;

`ifdef IIR_ALLPOLE_SAT_EN
  assign w_y = DW'(sat_to(w_acc_shift, DW));
`else
  assign w_y = DW'(wrap_to(w_acc_shift, DW));
`endif

  iir_coef_bank #(
    .NTAP (NTAP),
    .CW   (CW),
    .AW   (KW),
    .RAW  (KW + 1)
  ) u_coef_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_idle    (r_state == IDLE),
    .i_we      (coef_we),
    .i_addr    (coef_addr),
    .i_data    (coef_data),
    .i_rd_addr (r_k),
    .o_rd_data (w_coef)
  );

  // History tap select for the current k.
  always_comb begin
    w_yh_k = '0;
    for (int i = 1; i <= NTAP; i++) begin
      w_yh_k = (r_k == (KW + 1)'(i)) ? r_yh[i] : w_yh_k;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; clr overrides everything.
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = w_accept ? MAC : IDLE;
        MAC:     w_next = w_mac_step ? MAC : OUT;
        OUT:     w_next = out_ready ? IDLE : OUT;
        default: w_next = IDLE;
      endcase
    end
  end

  // Accumulator, tap counter, history and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_k       <= '0;
      r_ntap_q  <= '0;
      out_valid <= 1'b0;
      y_out     <= '0;
      for (int i = 1; i <= NTAP; i++) r_yh[i] <= '0;
    end else if (clr) begin
      r_acc     <= '0;
      r_k       <= '0;
      out_valid <= 1'b0;
      for (int i = 1; i <= NTAP; i++) r_yh[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc    <= ACCW'(x_in) <<< CFRAC;
            r_k      <= (KW + 1)'(1);
            r_ntap_q <= w_ntap_in;
          end
        end
        MAC: begin
          if (w_mac_step) begin
            r_acc <= r_acc - ACCW'(w_prod);
            r_k   <= r_k + (KW + 1)'(1);
          end else begin
            y_out     <= w_y;
            out_valid <= 1'b1;
            r_yh[1]   <= w_y;
            for (int i = 2; i <= NTAP; i++) r_yh[i] <= r_yh[i-1];
          end
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IIR_ALLPOLE_SAT_EN
  // Sticky saturation indicator, raised when a finalised sample was clipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (clr) begin
      sat_flag <= 1'b0;
    end else if ((r_state == MAC) && !w_mac_step &&
                 (sat_to(w_acc_shift, DW) != w_acc_shift)) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_iir_allpole_serial.sv
// Directed self-checking bench for iir_allpole_serial (default parameters).
// Build with IIR_ALLPOLE_SAT_EN defined to exercise the saturating variant.
module tb_iir_allpole_serial;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] y_out;
  logic [3:0]        n_taps;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              clr;
`ifdef IIR_ALLPOLE_SAT_EN
  logic              sat_flag;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  iir_allpole_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .n_taps    (n_taps),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .clr       (clr)
`ifdef IIR_ALLPOLE_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  task automatic write_coef(input int addr, input int data);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 8'(data);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic run_sample(input string tag, input int x, input int nt,
                            input int exp_y, input int exp_lat);
    int lat;
    @(negedge clk);
    check_val({tag, "_in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    x_in     = 8'(x);
    n_taps   = 4'(nt);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check_val({tag, "_latency"}, lat, exp_lat);
    check_val({tag, "_y"}, int'(y_out), exp_y);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check_val({tag, "_valid_drop"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; x_in = '0; out_ready = 1'b1; n_taps = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_in_ready", int'(in_ready), 1);
    check_val("rst_y_out", int'(y_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while a sample is mid-MAC, then cold start.
    write_coef(1, -32);
    run_sample("pre_rst", -7, 0, -7, 1);
    @(negedge clk);
    in_valid = 1'b1; x_in = 8'sd50; n_taps = 4'd8;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_mac_busy", int'(in_ready), 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", int'(out_valid), 0);
    check_val("async_rst_ready", int'(in_ready), 1);
    check_val("async_rst_y", int'(y_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample("cold0", 20, 1, 20, 2);
    run_sample("cold1", 20, 1, 20, 2);

    // Passthrough.
    run_sample("pass_pos", 37, 0, 37, 1);
    run_sample("pass_neg", -5, 0, -5, 1);

    // Impulse response with a[1] = -0.5, then tap count clamped to NTAP.
    pulse_clr();
    write_coef(1, -32);
    run_sample("imp0", 64, 1, 64, 2);
    run_sample("imp1", 0, 1, 32, 2);
    run_sample("imp2", 0, 1, 16, 2);
    run_sample("imp3", 0, 1, 8, 2);
    run_sample("clamp", 0, 12, 4, 9);

    // Backpressure: output held, new input refused.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; x_in = 8'sd11; n_taps = 4'd0;
    @(posedge clk);
    #1;
    x_in = 8'sd99;
    wait_valid(lat);
    check_val("bp_latency", lat, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_val("bp_hold_valid", int'(out_valid), 1);
      check_val("bp_hold_y", int'(y_out), 11);
      check_val("bp_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    check_val("bp_release_valid", int'(out_valid), 0);
    check_val("bp_release_ready", int'(in_ready), 1);
    run_sample("bp_next", 99, 0, 99, 1);

    // Overflow with a[1] = -1.0.
    pulse_clr();
    write_coef(1, -64);
    run_sample("ovf0", 100, 1, 100, 2);
`ifdef IIR_ALLPOLE_SAT_EN
    check_val("sat_flag_clear", int'(sat_flag), 0);
    run_sample("ovf1", 100, 1, 127, 2);
    check_val("sat_flag_set", int'(sat_flag), 1);
    pulse_clr();
    check_val("sat_flag_clr", int'(sat_flag), 0);
`else
    run_sample("ovf1", 100, 1, -56, 2);
`endif

    // Ignored coefficient write during MAC, then abort of the second sample.
    pulse_clr();
    write_coef(1, -32);
    @(negedge clk);
    in_valid = 1'b1; x_in = 8'sd64; n_taps = 4'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 4'd1; coef_data = 8'sd10;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    wait_valid(lat);
    check_val("abort_s1_y", int'(y_out), 64);
    @(posedge clk);
    #1;
    @(negedge clk);
    in_valid = 1'b1; x_in = 8'sd0; n_taps = 4'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_val("abort_valid", int'(out_valid), 0);
    check_val("abort_ready", int'(in_ready), 1);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check_val("abort_no_output", seen, 0);
    run_sample("after_abort0", 64, 1, 64, 2);
    run_sample("after_abort1", 0, 1, 32, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
